// File: rtl/reg5_read_buffer.sv
// reg5_read_buffer: circular read buffer behind a 5-bit write-enable register, drained via valid/ready
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (clears pointers, count, overflow)
//   i_data_in   in   word offered by the writer
//   i_write_en  in   writer strobe, one word per cycle
//   o_full      out  buffer holds DEPTH words
//   o_data_out  out  head word, 0 when nothing is queued
//   o_out_valid out  head word present
//   i_out_ready in   reader takes the head this cycle
//   o_count     out  occupied entries, 0..DEPTH
//   o_overflow  out  sticky flag, a write was dropped
module reg5_read_buffer #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i_data_in,
    input  logic              i_write_en,
    output logic              o_full,
    output logic [WIDTH-1:0]  o_data_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow
);
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              w_pop;
    logic              w_write;

    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_out_valid = r_count != '0;
    assign o_full      = r_count == (ADDR_W+1)'(DEPTH);
    assign o_data_out  = o_out_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop       = o_out_valid & i_out_ready;
    // a full buffer can still take a word when the head leaves in the same cycle
    assign w_write     = i_write_en & (~o_full | w_pop);

    always_ff @(posedge clk)
        if (!rst && w_write) r_mem[r_wr_ptr] <= i_data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= (w_write && !w_pop) ? r_count + 1'b1 :
                          (w_pop && !w_write) ? r_count - 1'b1 : r_count;
            r_overflow <= r_overflow | (i_write_en & o_full & ~w_pop);
        end
    end
endmodule

// File: tb/tb_reg5_read_buffer.sv
// tb_reg5_read_buffer: directed and random checks of reg5_read_buffer against a queue model
module tb_reg5_read_buffer;
    localparam int DEPTH = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] data_in = '0;
    logic       write_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       full;
    logic [4:0] data_out;
    logic       out_valid;
    logic [2:0] count;
    logic       overflow;
    int         n_vec = 0;
    int         n_err = 0;
    int         q[$];
    bit         m_ovf = 1'b0;
    int         seen[$];

    reg5_read_buffer dut (
        .clk(clk), .rst(rst), .i_data_in(data_in), .i_write_en(write_en),
        .o_full(full), .o_data_out(data_out), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_count(count), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit we, input int d, input bit rd);
        bit pop, wr;
        rst = rs;
        write_en = we;
        data_in = 5'(d);
        out_ready = rd;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop = q.size() != 0 && rd;
            wr = we && (q.size() < DEPTH || pop);
            if (we && q.size() == DEPTH && !pop) m_ovf = 1'b1;
            if (pop) seen.push_back(q.pop_front());
            if (wr) q.push_back(d & 31);
        end
        @(negedge clk);
        check("count", int'(count), q.size());
        check("out_valid", int'(out_valid), int'(q.size() != 0));
        check("data_out", int'(data_out), q.size() != 0 ? q[0] : 0);
        check("full", int'(full), int'(q.size() == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
    endtask

    initial begin
        // T1: reset dominates a write
        step(1, 1, 'h1F, 0);
        step(1, 1, 'h1F, 0);
        check("t1_count", int'(count), 0);
        check("t1_data", int'(data_out), 0);
        // T2: single word held while the reader stalls
        step(0, 1, 'h03, 0);
        check("t2_data", int'(data_out), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("t2_held", int'(data_out), 3);
        // T3: fill, overflow, drain in order
        step(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
        check("t3_full", int'(full), 1);
        step(0, 1, 'h1F, 0);
        check("t3_ovf", int'(overflow), 1);
        check("t3_count", int'(count), 4);
        seen.delete();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("t3_drained", seen.size(), 4);
        for (int i = 0; i < 4; i++) check("t3_order", seen.size() > i ? seen[i] : -1, i + 1);
        // T4: write into a full buffer together with a pop
        step(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
        step(0, 1, 5, 1);
        check("t4_count", int'(count), 4);
        check("t4_ovf", int'(overflow), 0);
        check("t4_head", int'(data_out), 2);
        // T5: streaming through the wrap with one-cycle latency
        step(1, 0, 0, 0);
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, i, 1);
            check("t5_cnt_le2", int'(count <= 2), 1);
        end
        step(0, 0, 0, 1);
        check("t5_seen", seen.size(), 10);
        for (int i = 0; i < 10; i++) check("t5_order", seen.size() > i ? seen[i] : -1, i);
        // T6: reset while holding words discards them
        for (int i = 0; i < 3; i++) step(0, 1, 7 + i, 0);
        step(1, 1, 'h11, 1);
        check("t6_count", int'(count), 0);
        check("t6_valid", int'(out_valid), 0);
        step(0, 1, 'h0A, 0);
        check("t6_data", int'(data_out), 'h0A);
        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
